// File: rtl/data_mem_unit.sv
// data_mem_unit: single-port word RAM with byte/half/word load-store access.
// Each accepted request takes three cycles: IDLE (accept) -> BUSY (RAM
// access using the latched request) -> RESP (one-cycle response strobe).
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset (RAM contents are kept)
//   req_valid  request present
//   req_ready  high only in IDLE
//   mem_op     0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0110 LHU,
//              1001 SB, 1010 SH, 1111 SW; anything else is illegal
//   addr       byte address
//   wdata      store data (low byte/half/word used)
//   rsp_valid  one-cycle response strobe
//   rdata      load result, extended to 32 bits; 0 for stores and faults
//   err        access faulted (misaligned, out of range or illegal op)
module data_mem_unit #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [3:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rd_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  // Decode of the latched request
  logic          is_load, is_store, sext;
  logic [1:0]    sz;              // 0 byte, 1 half, 2 word
  logic          misalign, oor, fault, we;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word_rd, ld, wd;
  logic [3:0]    be;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    sz       = 2'd0;
    case (op_q)
      4'b0001: begin is_load  = 1'b1; sz = 2'd0; sext = 1'b1; end
      4'b0010: begin is_load  = 1'b1; sz = 2'd1; sext = 1'b1; end
      4'b0011: begin is_load  = 1'b1; sz = 2'd2; end
      4'b0100: begin is_load  = 1'b1; sz = 2'd0; end
      4'b0110: begin is_load  = 1'b1; sz = 2'd1; end
      4'b1001: begin is_store = 1'b1; sz = 2'd0; end
      4'b1010: begin is_store = 1'b1; sz = 2'd1; end
      4'b1111: begin is_store = 1'b1; sz = 2'd2; end
      default: ;
    endcase
  end

  assign idx      = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign misalign = ((sz == 2'd1) && addr_q[0]) || ((sz == 2'd2) && (addr_q[1:0] != 2'b00));
  // Any set bit above the word index puts the word address past DEPTH.
  assign oor      = |addr_q[31:AW+2];
  assign fault    = !(is_load || is_store) || misalign || oor;
  assign we       = (state == BUSY) && is_store && !fault;

  assign word_rd  = mem[idx];
  assign byte_sel = word_rd[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    ld = word_rd;
    be = '0;
    wd = wdata_q;
    case (sz)
      2'd0: begin
        ld       = {{24{sext & byte_sel[7]}}, byte_sel};
        be[lane] = 1'b1;
        wd       = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        ld = {{16{sext & half_sel[15]}}, half_sel};
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        ld = word_rd;
        be = '1;
        wd = wdata_q;
      end
    endcase
  end

  // RAM has no reset; an async reset during BUSY drops state to IDLE before
  // the committing edge, so the write is suppressed.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        op_q    <= mem_op;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == BUSY) begin
        err_q <= fault;
        rd_q  <= (is_load && !fault) ? ld : '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = BUSY;
      BUSY:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rdata     = rsp_valid ? rd_q : '0;
  assign err       = rsp_valid & err_q;

endmodule
